// File: rtl/carp_boruhatti_if.sv
// Execute-stage multiplier bus: issue side (operands, op, tag, flush) and
// writeback side (result, tag), each with a valid/ready pair.
interface carp_boruhatti_if #(
  parameter int VERI_GENISLIGI   = 32,
  parameter int ETIKET_GENISLIGI = 5
);
  logic                        giris_gecerli_i;
  logic                        giris_hazir_o;
  logic [VERI_GENISLIGI-1:0]   ilksayi_i;
  logic [VERI_GENISLIGI-1:0]   ikincisayi_i;
  logic [1:0]                  buyruk_i;
  logic [ETIKET_GENISLIGI-1:0] etiket_i;
  logic                        temizle_i;
  logic                        cikis_gecerli_o;
  logic                        cikis_hazir_i;
  logic [VERI_GENISLIGI-1:0]   sonuc_o;
  logic [ETIKET_GENISLIGI-1:0] etiket_o;

  modport master (
    output giris_gecerli_i, ilksayi_i, ikincisayi_i, buyruk_i, etiket_i,
           temizle_i, cikis_hazir_i,
    input  giris_hazir_o, cikis_gecerli_o, sonuc_o, etiket_o
  );

  modport slave (
    input  giris_gecerli_i, ilksayi_i, ikincisayi_i, buyruk_i, etiket_i,
           temizle_i, cikis_hazir_i,
    output giris_hazir_o, cikis_gecerli_o, sonuc_o, etiket_o
  );
endinterface

// File: rtl/carp_boruhatti.sv
// Pipelined RV32M/RV64M multiplier: full product formed at issue, then carried
// through ASAMA_SAYISI register stages with a passthrough tag and global stall.
module carp_boruhatti #(
  parameter int VERI_GENISLIGI   = 32,
  parameter int ASAMA_SAYISI     = 2,
  parameter int ETIKET_GENISLIGI = 5
) (
  input logic              clk_i,
  input logic              rst_i,
  carp_boruhatti_if.slave  bus
);
  localparam int W = VERI_GENISLIGI;
  localparam int D = ASAMA_SAYISI;
  localparam int T = ETIKET_GENISLIGI;

  logic             ilerle;
  logic             giris_hazir;
  logic             kabul;
  logic             isaret_a;
  logic             isaret_b;
  logic [W:0]       a_ext;
  logic [W:0]       b_ext;
  logic [2*W+1:0]   carpim;
  logic [W-1:0]     sonuc_hesap;
  logic [1:0]       unused_carpim_ust;

  logic [D-1:0]     vld_q, vld_d;
  logic [W-1:0]     veri_q [D];
  logic [W-1:0]     veri_d [D];
  logic [T-1:0]     etk_q  [D];
  logic [T-1:0]     etk_d  [D];

  // Stall is decided by the last stage only; bubbles never compact.
  assign ilerle      = !vld_q[D-1] || bus.cikis_hazir_i;
  assign giris_hazir = ilerle && !bus.temizle_i && !rst_i;
  assign kabul       = bus.giris_gecerli_i && giris_hazir;

  // W+1-bit sign/zero extension then a 2W+2-bit multiply covers all four forms.
  assign isaret_a = (bus.buyruk_i != 2'b11) && bus.ilksayi_i[W-1];
  assign isaret_b = (bus.buyruk_i == 2'b00 || bus.buyruk_i == 2'b01) && bus.ikincisayi_i[W-1];
  assign a_ext    = {isaret_a, bus.ilksayi_i};
  assign b_ext    = {isaret_b, bus.ikincisayi_i};
  assign carpim   = {{(W+1){a_ext[W]}}, a_ext} * {{(W+1){b_ext[W]}}, b_ext};

  assign sonuc_hesap       = (bus.buyruk_i == 2'b00) ? carpim[W-1:0] : carpim[2*W-1:W];
  assign unused_carpim_ust = carpim[2*W+1:2*W];

  always_comb begin
    vld_d  = vld_q;
    veri_d = veri_q;
    etk_d  = etk_q;
    if (bus.temizle_i) begin
      vld_d = '0;
    end else if (ilerle) begin
      vld_d[0]  = kabul;
      veri_d[0] = kabul ? sonuc_hesap  : veri_q[0];
      etk_d[0]  = kabul ? bus.etiket_i : etk_q[0];
      for (int i = 1; i < D; i++) begin
        vld_d[i]  = vld_q[i-1];
        veri_d[i] = veri_q[i-1];
        etk_d[i]  = etk_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < D; i++) begin
        veri_q[i] <= '0;
        etk_q[i]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < D; i++) begin
        veri_q[i] <= veri_d[i];
        etk_q[i]  <= etk_d[i];
      end
    end
  end

  assign bus.giris_hazir_o   = giris_hazir;
  assign bus.cikis_gecerli_o = vld_q[D-1];
  assign bus.sonuc_o         = veri_q[D-1];
  assign bus.etiket_o        = etk_q[D-1];
endmodule

// File: tb/tb_carp_boruhatti.sv
// Directed and randomised checks of carp_boruhatti at W=32/depth 2 and
// W=64/depth 4, with a 128-bit reference for the random traffic.
module tb_carp_boruhatti;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  carp_boruhatti_if #(.VERI_GENISLIGI(32), .ETIKET_GENISLIGI(5)) b32();
  carp_boruhatti_if #(.VERI_GENISLIGI(64), .ETIKET_GENISLIGI(5)) b64();

  carp_boruhatti #(.VERI_GENISLIGI(32), .ASAMA_SAYISI(2), .ETIKET_GENISLIGI(5)) u32 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b32)
  );

  carp_boruhatti #(.VERI_GENISLIGI(64), .ASAMA_SAYISI(4), .ETIKET_GENISLIGI(5)) u64 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b64)
  );

  typedef struct {
    logic [63:0] r;
    logic [4:0]  t;
  } beklenti_t;

  beklenti_t kuyruk[$];

  logic [1:0]  bb_op [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic [31:0] bb_a  [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
  logic [31:0] bb_b  [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] bb_r  [4] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000};

  logic [1:0]  d64_op [3] = '{2'b01, 2'b10, 2'b11};
  logic [63:0] d64_a  [3] = '{64'h8000000000000000, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF};
  logic [63:0] d64_b  [3] = '{64'h8000000000000000, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF};
  logic [63:0] d64_r  [3] = '{64'h4000000000000000, 64'hC000000000000000, 64'hFFFFFFFFFFFFFFFE};

  logic [1:0]  r_op;
  logic [63:0] r_a, r_b;
  logic [4:0]  r_t;
  logic        r_g, r_h, r_f;
  int          kabul_sayisi;
  int          dongu;

  task automatic kontrol(input string ad, input logic [127:0] gozlenen, input logic [127:0] beklenen);
    checks++;
    assert (gozlenen === beklenen)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", ad, gozlenen, beklenen);
    end
  endtask

  task automatic tik();
    @(posedge clk);
    #1;
  endtask

  task automatic sur32(input logic g, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t);
    b32.giris_gecerli_i = g;
    b32.buyruk_i        = op;
    b32.ilksayi_i       = a;
    b32.ikincisayi_i    = b;
    b32.etiket_i        = t;
  endtask

  task automatic sur64(input logic g, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] t);
    b64.giris_gecerli_i = g;
    b64.buyruk_i        = op;
    b64.ilksayi_i       = a;
    b64.ikincisayi_i    = b;
    b64.etiket_i        = t;
  endtask

  // Unsigned product with two's-complement corrections for signed operands.
  function automatic logic [63:0] model64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    if ((op == 2'b01 || op == 2'b10) && a[63]) p = p - {b, 64'd0};
    if (op == 2'b01 && b[63]) p = p - {a, 64'd0};
    return (op == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0:       return 64'h8000000000000000;
      1:       return 64'hFFFFFFFFFFFFFFFF;
      2:       return 64'h0000000000000001;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    sur32(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    sur64(1'b0, 2'b00, 64'd0, 64'd0, 5'd0);
    b32.temizle_i = 1'b0;  b32.cikis_hazir_i = 1'b1;
    b64.temizle_i = 1'b0;  b64.cikis_hazir_i = 1'b1;
    rst = 1'b1;
    tik();
    tik();
    kontrol("rst_hazir32",   128'(b32.giris_hazir_o),   128'(0));
    kontrol("rst_gecerli32", 128'(b32.cikis_gecerli_o), 128'(0));
    kontrol("rst_sonuc32",   128'(b32.sonuc_o),         128'(0));
    kontrol("rst_etiket32",  128'(b32.etiket_o),        128'(0));
    kontrol("rst_gecerli64", 128'(b64.cikis_gecerli_o), 128'(0));
    kontrol("rst_sonuc64",   128'(b64.sonuc_o),         128'(0));
    rst = 1'b0;
    #1;
    kontrol("hazir_cikis", 128'(b32.giris_hazir_o), 128'(1));

    // single mul, latency 2
    sur32(1'b1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
    tik();
    sur32(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    kontrol("lat_erken", 128'(b32.cikis_gecerli_o), 128'(0));
    tik();
    kontrol("lat_gecerli", 128'(b32.cikis_gecerli_o), 128'(1));
    kontrol("lat_sonuc",   128'(b32.sonuc_o),         128'(32'h00000001));
    kontrol("lat_etiket",  128'(b32.etiket_o),        128'(3));

    // back-to-back
    for (int t = 1; t <= 6; t++) begin
      if (t <= 4) sur32(1'b1, bb_op[t-1], bb_a[t-1], bb_b[t-1], 5'(t + 3));
      else        sur32(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
      tik();
      if (t >= 2 && t <= 5) begin
        kontrol("bb_gecerli", 128'(b32.cikis_gecerli_o), 128'(1));
        kontrol("bb_sonuc",   128'(b32.sonuc_o),         128'(bb_r[t-2]));
        kontrol("bb_etiket",  128'(b32.etiket_o),        128'(t + 2));
      end else begin
        kontrol("bb_bos", 128'(b32.cikis_gecerli_o), 128'(0));
      end
    end

    // backpressure
    b32.cikis_hazir_i = 1'b0;
    sur32(1'b1, 2'b00, 32'h00012345, 32'h00001000, 5'd8);
    tik();
    sur32(1'b1, 2'b00, 32'd7, 32'd6, 5'd9);
    tik();
    sur32(1'b1, 2'b11, 32'hFFFFFFFF, 32'd2, 5'd10);
    #1;
    kontrol("bp_hazir", 128'(b32.giris_hazir_o), 128'(0));
    for (int k = 0; k < 5; k++) begin
      tik();
      kontrol("bp_gecerli", 128'(b32.cikis_gecerli_o), 128'(1));
      kontrol("bp_sonuc",   128'(b32.sonuc_o),         128'(32'h12345000));
      kontrol("bp_etiket",  128'(b32.etiket_o),        128'(8));
      kontrol("bp_hazir",   128'(b32.giris_hazir_o),   128'(0));
    end
    b32.cikis_hazir_i = 1'b1;
    #1;
    kontrol("bp_birak", 128'(b32.giris_hazir_o), 128'(1));
    tik();
    sur32(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    kontrol("bp_b_sonuc",  128'(b32.sonuc_o),  128'(32'h0000002A));
    kontrol("bp_b_etiket", 128'(b32.etiket_o), 128'(9));
    tik();
    kontrol("bp_c_gecerli", 128'(b32.cikis_gecerli_o), 128'(1));
    kontrol("bp_c_sonuc",   128'(b32.sonuc_o),         128'(32'h00000001));
    kontrol("bp_c_etiket",  128'(b32.etiket_o),        128'(10));
    tik();
    kontrol("bp_son", 128'(b32.cikis_gecerli_o), 128'(0));

    // flush
    sur32(1'b1, 2'b00, 32'd100, 32'd3, 5'd12);
    tik();
    sur32(1'b1, 2'b01, 32'h40000000, 32'd4, 5'd13);
    tik();
    kontrol("fl_once", 128'(b32.sonuc_o), 128'(32'd300));
    b32.temizle_i = 1'b1;
    sur32(1'b1, 2'b00, 32'd5, 32'd5, 5'd14);
    #1;
    kontrol("fl_hazir", 128'(b32.giris_hazir_o), 128'(0));
    tik();
    b32.temizle_i = 1'b0;
    sur32(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      kontrol("fl_bos", 128'(b32.cikis_gecerli_o), 128'(0));
      tik();
    end

    // reset mid-operation
    sur32(1'b1, 2'b00, 32'd3, 32'd5, 5'd11);
    tik();
    sur32(1'b1, 2'b00, 32'd9, 32'd9, 5'd15);
    tik();
    kontrol("rs_once", 128'(b32.sonuc_o), 128'(15));
    rst = 1'b1;
    sur32(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    tik();
    kontrol("rs_gecerli", 128'(b32.cikis_gecerli_o), 128'(0));
    kontrol("rs_sonuc",   128'(b32.sonuc_o),         128'(0));
    kontrol("rs_etiket",  128'(b32.etiket_o),        128'(0));
    kontrol("rs_hazir",   128'(b32.giris_hazir_o),   128'(0));
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tik();
      kontrol("rs_bos", 128'(b32.cikis_gecerli_o), 128'(0));
    end

    // W=64, depth 4
    for (int v = 0; v < 3; v++) begin
      sur64(1'b1, d64_op[v], d64_a[v], d64_b[v], 5'(v + 1));
      for (int t = 1; t <= 4; t++) begin
        tik();
        if (t == 1) sur64(1'b0, 2'b00, 64'd0, 64'd0, 5'd0);
        if (t < 4) begin
          kontrol("w64_erken", 128'(b64.cikis_gecerli_o), 128'(0));
        end else begin
          kontrol("w64_gecerli", 128'(b64.cikis_gecerli_o), 128'(1));
          kontrol("w64_sonuc",   128'(b64.sonuc_o),         128'(d64_r[v]));
          kontrol("w64_etiket",  128'(b64.etiket_o),        128'(v + 1));
        end
      end
      tik();
    end

    // random traffic with scoreboard
    kabul_sayisi = 0;
    dongu = 0;
    while (kabul_sayisi < 10000 && dongu < 60000) begin
      dongu++;
      r_op = 2'($urandom_range(0, 3));
      r_a  = rnd64();
      r_b  = rnd64();
      r_t  = 5'($urandom_range(0, 31));
      r_g  = ($urandom_range(0, 3) != 0);
      r_h  = ($urandom_range(0, 3) != 0);
      r_f  = ($urandom_range(0, 49) == 0);
      sur64(r_g, r_op, r_a, r_b, r_t);
      b64.cikis_hazir_i = r_h;
      b64.temizle_i     = r_f;
      #1;
      kontrol("rnd_hazir", 128'(b64.giris_hazir_o),
              128'((!b64.cikis_gecerli_o || r_h) && !r_f));
      if (r_f) begin
        kuyruk.delete();
      end else begin
        if (kuyruk.size() == 0) begin
          kontrol("rnd_bos", 128'(b64.cikis_gecerli_o), 128'(0));
        end else if (b64.cikis_gecerli_o && r_h) begin
          kontrol("rnd_sonuc", 128'({b64.sonuc_o, b64.etiket_o}),
                  128'({kuyruk[0].r, kuyruk[0].t}));
          void'(kuyruk.pop_front());
        end
        if (r_g && b64.giris_hazir_o) begin
          kuyruk.push_back('{r: model64(r_op, r_a, r_b), t: r_t});
          kabul_sayisi++;
        end
      end
      tik();
    end
    kontrol("rnd_butce", 128'(kabul_sayisi >= 10000), 128'(1));

    sur64(1'b0, 2'b00, 64'd0, 64'd0, 5'd0);
    b64.cikis_hazir_i = 1'b1;
    b64.temizle_i     = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (kuyruk.size() != 0 && b64.cikis_gecerli_o) begin
        kontrol("rnd_bosalt", 128'({b64.sonuc_o, b64.etiket_o}),
                128'({kuyruk[0].r, kuyruk[0].t}));
        void'(kuyruk.pop_front());
      end
      tik();
    end
    kontrol("rnd_kalan",   128'(kuyruk.size()),         128'(0));
    kontrol("rnd_son_bos", 128'(b64.cikis_gecerli_o),   128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/carp_boruhatti.md
Name: carp_boruhatti

Overview:
Pipelined, parametrised RV32M/RV64M integer multiplier for the execute (yurut) stage. It replaces the single-cycle combinational multiplier with a pipeline of ASAMA_SAYISI register stages, valid/ready handshakes on both sides, and a destination tag passed through alongside each result. It accepts one operation per cycle, supports backpressure from writeback, and drops all in-flight operations on a flush from the branch unit.

Parameters:
VERI_GENISLIGI, 32, operand/result width W (32 or 64)
ASAMA_SAYISI, 2, pipeline depth/latency in cycles (1..4)
ETIKET_GENISLIGI, 5, width of passthrough tag (rd address)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous active-high reset
giris_gecerli_i  input  1  operation valid at input
giris_hazir_o  output  1  multiplier can accept this cycle
ilksayi_i  input  W  rs1 operand
ikincisayi_i  input  W  rs2 operand
buyruk_i  input  2  mul=00, mulh=01, mulhsu=10, mulhu=11
etiket_i  input  ETIKET_GENISLIGI  tag travelling with the operation
temizle_i  input  1  flush: kill all in-flight operations
cikis_gecerli_o  output  1  result valid
cikis_hazir_i  input  1  consumer accepts result
sonuc_o  output  W  result
etiket_o  output  ETIKET_GENISLIGI  tag of the result

Behaviour:
- Clock and reset: one clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values: all stage valid bits, cikis_gecerli_o, sonuc_o and etiket_o are 0. giris_hazir_o is 0 while rst_i=1.
- Reset mid-operation: every in-flight operation is discarded; no result from it ever appears.
- Arithmetic: form the 2W-bit product P.
  - mul, mulh: signed x signed.
  - mulhsu: signed rs1 x unsigned rs2.
  - mulhu: unsigned x unsigned.
  - mul returns P[W-1:0]; the other three return P[2W-1:W].
  - Results must be bit-exact to the RISC-V M spec, including the most-negative operand (0x8000...0) for all signed forms.
  - Implementation choice (magnitude + sign fix, or sign-extended W+1 multiply) is free. The result must be identical to a full 2W-bit multiply.
- Pipeline: global advance signal ilerle = !cikis_gecerli_o || cikis_hazir_i.
  - giris_hazir_o = ilerle && !temizle_i && !rst_i.
  - The input is accepted when giris_gecerli_i && giris_hazir_o.
  - When ilerle=1, every stage shifts one place. When ilerle=0, every stage holds, including data and tag.
- Latency and throughput:
  - An operation accepted at edge N drives cikis_gecerli_o=1 after edge N+ASAMA_SAYISI, provided there are no stalls.
  - With the output never stalled, throughput is one result per cycle.
  - Results leave in acceptance order.
- Output handshake:
  - A result is consumed at the edge where cikis_gecerli_o && cikis_hazir_i.
  - While cikis_gecerli_o=1 and cikis_hazir_i=0, sonuc_o and etiket_o stay stable.
- Bubbles: an invalid slot shifts through like a valid one. Stages are not compacted.
  - Stall is decided by the last stage only, so a bubble does not unblock an upstream stall.
- Flush: temizle_i=1 at an edge clears every stage valid bit, including the output stage, even if that output is being consumed in the same cycle.
  - No input is accepted in a flush cycle.
  - Data registers may keep stale values, but cikis_gecerli_o=0 on the next cycle.
- Priority: rst_i > temizle_i > normal advance.
- The valid and tag path must work with ASAMA_SAYISI=1, where input registers feed the output directly.
- The multiply may be split across stages (partial products) or placed in stage 1 with retiming. Only the external latency contract is fixed.
- buyruk_i, operands and etiket_i are sampled only on accept. Their values at other times have no effect.

Test Plan:
- W=32, depth 2, cikis_hazir_i=1; accept mul 0xFFFFFFFF x 0xFFFFFFFF tag 3 -> valid exactly 2 cycles later, sonuc_o=0x00000001, etiket_o=3.
- Back-to-back, one per cycle:
  - mulh 0x80000000 x 0x80000000 -> 0x40000000
  - mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF
  - mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE
  - mul 0x80000000 x 0xFFFFFFFF -> 0x80000000
  - Required: four consecutive valid cycles, in order.
- Backpressure: cikis_hazir_i=0 for 5 cycles while a result is valid -> giris_hazir_o=0, sonuc_o/etiket_o stable. On release the pipeline resumes with no loss or duplication.
- Flush:
  - Issue 2 operations, assert temizle_i for 1 cycle while one is in stage 1 and one is at the output -> no valid output afterwards.
  - An operation presented during the flush cycle is not accepted (giris_hazir_o=0).
- Reset mid-operation: assert rst_i with 2 operations in flight -> all outputs 0 the next cycle, and no stale result after rst_i is released.
- W=64, depth 4: mulh 0x8000000000000000 x 0x8000000000000000 -> 0x4000000000000000, latency 4. Add a randomised 10k-operation check against a 128-bit reference model under random valid/ready/flush.
